sort4_ctrl: RTL and testbench

SORT4_CTRL -- requirements
Module: sort4_ctrl

---
 rtl/sort4_ctrl.sv | 129 ++++++++++++
 tb/tb_sort4_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sort4_ctrl.sv
// sort4_ctrl: loads four 4-bit words, bubble-sorts them in place with a fixed
// six-compare schedule through a single magnitude comparator, then drains them
// in sorted order over a valid/ready stream.
// Optional build macro: SORT4_DESCENDING_EN (descending order when defined).

module comp (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [2:0] y
);
  // y[2]: a>b, y[1]: a==b, y[0]: a<b
  assign y = {a > b, a == b, a < b};
endmodule

module sort4_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_data,
  output logic       busy,
  output logic [2:0] swap_cnt
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] mem [4];
  logic [1:0] ld_idx;
  logic [1:0] rd_idx;
  logic [1:0] pass;
  logic [1:0] j;
  logic [1:0] jp1;
  logic [2:0] cmp_y;
  logic       do_swap;
  logic       last_in_pass;
  logic       last_cmp;

  assign jp1          = j + 2'd1;
  assign last_in_pass = (j == (2'd2 - pass));
  assign last_cmp     = (pass == 2'd2);

  // The only ordering decision in the block: mem[j] versus mem[j+1]
  comp u_comp (
    .a (mem[j]),
    .b (mem[jp1]),
    .y (cmp_y)
  );

  // Full-code match keeps equal elements unswapped and uses every comparator bit
`ifdef SORT4_DESCENDING_EN
  assign do_swap = (cmp_y == 3'b001);
`else
  assign do_swap = (cmp_y == 3'b100);
`endif

  // Outputs decode straight from registered state/data, no input-to-output paths
  assign in_ready  = (state == LOAD);
  assign out_valid = (state == DRAIN);
  assign busy      = (state != LOAD);
  assign out_data  = (state == DRAIN) ? mem[rd_idx] : 4'd0;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (in_valid && ld_idx == 2'd3) state_nxt = SORT;
      SORT:    if (last_cmp) state_nxt = DRAIN;
      DRAIN:   if (out_ready && rd_idx == 2'd3) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Datapath: load, compare-and-swap schedule, drain pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_idx   <= 2'd0;
      rd_idx   <= 2'd0;
      pass     <= 2'd0;
      j        <= 2'd0;
      swap_cnt <= 3'd0;
      for (int i = 0; i < 4; i++) mem[i] <= 4'd0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            mem[ld_idx] <= in_data;
            ld_idx      <= ld_idx + 2'd1;
            if (ld_idx == 2'd0) swap_cnt <= 3'd0;
          end
        end
        SORT: begin
          if (do_swap) begin
            mem[j]   <= mem[jp1];
            mem[jp1] <= mem[j];
            swap_cnt <= swap_cnt + 3'd1;
          end
          if (last_cmp) begin
            pass <= 2'd0;
            j    <= 2'd0;
          end else if (last_in_pass) begin
            pass <= pass + 2'd1;
            j    <= 2'd0;
          end else begin
            j <= jp1;
          end
        end
        DRAIN: begin
          if (out_ready) rd_idx <= rd_idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sort4_ctrl.sv
// Scoreboard bench for sort4_ctrl: expected sorted words are queued when a set
// is loaded and popped as the block transfers them out.
`timescale 1ns/1ps

module tb_sort4_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       busy;
  logic [2:0] swap_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_q[$];

  sort4_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .swap_cnt  (swap_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: same fixed six-compare bubble schedule on a local copy
  task automatic model(input int v[4], output int swaps);
    int a[4];
    int t;
    a = v;
    swaps = 0;
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 3 - p; k++) begin
`ifdef SORT4_DESCENDING_EN
        if (a[k] < a[k+1]) begin
`else
        if (a[k] > a[k+1]) begin
`endif
          t = a[k]; a[k] = a[k+1]; a[k+1] = t; swaps++;
        end
      end
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(a[i]);
  endtask

  task automatic run_set(input int v[4], input int toggle, input int jam);
    int sw;
    int t0;
    int first_cyc;
    int n;
    int k;
    bit rdy;
    exp_q.delete();
    model(v, sw);
    out_ready = 1'b0;
    t0 = 0;
    for (int i = 0; i < 4; i++) begin
      chk("load_in_ready", int'(in_ready), 1);
      in_valid = 1'b1;
      in_data  = 4'(v[i]);
      if (i == 3) t0 = cyc;
      tick;
      if (i == 0) chk("swap_cnt_clear", int'(swap_cnt), 0);
    end
    in_valid = jam ? 1'b1 : 1'b0;
    in_data  = 4'd5;
    first_cyc = -1;
    n = 0;
    k = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      if (!out_valid) begin
        chk("sort_in_ready", int'(in_ready), 0);
        chk("sort_busy", int'(busy), 1);
        out_ready = 1'b0;
      end else begin
        if (first_cyc < 0) begin
          first_cyc = cyc;
          chk("latency", cyc - t0, 7);
        end
        chk("out_data", int'(out_data), exp_q[0]);
        chk("drain_in_ready", int'(in_ready), 0);
        rdy = toggle ? (k % 2 == 0) : 1'b1;
        k++;
        out_ready = rdy;
        if (rdy) begin
          void'(exp_q.pop_front());
          n++;
        end
      end
      tick;
    end
    if (n < 4) chk("timeout_outputs", n, 4);
    chk("drain_len", cyc - first_cyc, toggle ? 7 : 4);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("back_in_ready", int'(in_ready), 1);
    chk("back_busy", int'(busy), 0);
    chk("back_out_valid", int'(out_valid), 0);
    chk("swap_cnt", int'(swap_cnt), sw);
  endtask

  initial begin
    int s[4];
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    out_ready = 1'b0;
    tick;
    tick;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_swap_cnt", int'(swap_cnt), 0);
    rst = 1'b0;

    s = '{9, 3, 7, 1};   run_set(s, 0, 0);
    s = '{1, 2, 3, 4};   run_set(s, 0, 0);
    s = '{15, 15, 0, 0}; run_set(s, 1, 0);

    // Reset landing in the third SORT cycle abandons the set
    s = '{9, 3, 7, 1};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 4'(s[i]);
      tick;
    end
    in_valid = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mid_rst_in_ready", int'(in_ready), 1);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_swap_cnt", int'(swap_cnt), 0);
    chk("mid_rst_out_data", int'(out_data), 0);
    s = '{4, 2, 8, 6};   run_set(s, 0, 0);

    s = '{4, 3, 2, 1};   run_set(s, 0, 1);
    s = '{7, 7, 7, 7};   run_set(s, 1, 1);
    s = '{0, 15, 8, 15}; run_set(s, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
